mul_div_unit: RTL and testbench

Iterative multiply/divide unit with HI/LO registers for the multi-cycle CPU datapath. Takes its operands directly from the register file read outputs (`output_0`/`output_1`), runs a 32-step shift-add multiply or restoring divide, and holds the 64-bit result in HI/LO. MFHI/MFLO results are returned through a registered write-back port that drives the register file's `rw`/`write_idx`/`write_data` inputs.

---
 rtl/mul_div_unit_if.sv | 28 ++
 rtl/mul_div_unit.sv | 149 ++++++++++++++
 tb/tb_mul_div_unit.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Operand/result and move-from write-back bundle between the CPU datapath and mul_div_unit.
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mf_req;
  logic        mf_sel;
  logic [4:0]  mf_dst;
  logic        mf_stall;
  logic        wb_rw;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;

  modport master (
    output start, op, src_a, src_b, mf_req, mf_sel, mf_dst,
    input  busy, done, hi, lo, mf_stall, wb_rw, wb_idx, wb_data
  );

  modport slave (
    input  start, op, src_a, src_b, mf_req, mf_sel, mf_dst,
    output busy, done, hi, lo, mf_stall, wb_rw, wb_idx, wb_data
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-step shift-add multiply / restoring divide with HI/LO registers and a
// registered MFHI/MFLO write-back port.
module mul_div_unit (
  input logic          clock,
  input logic          reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {StIdle, StRun, StFinish} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;
  logic        div0_q, div0_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic [31:0] opnd_q, opnd_d;   // multiplicand (mul) or divisor (div) magnitude
  logic [63:0] acc_q, acc_d;     // product, or {remainder, dividend/quotient}
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        wb_rw_q, wb_rw_d;
  logic [4:0]  wb_idx_q, wb_idx_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic        busy, accept, mf_accept;
  logic        sign_a, sign_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] sum33, upper33;
  logic [63:0] prod_neg;

  assign busy      = (state_q != StIdle);
  assign accept    = bus.start && ((state_q == StIdle) || (state_q == StFinish));
  assign mf_accept = bus.mf_req && !busy;

  assign sign_a  = ~bus.op[0] & bus.src_a[31];
  assign sign_b  = ~bus.op[0] & bus.src_b[31];
  assign mag_a   = sign_a ? (32'd0 - bus.src_a) : bus.src_a;
  assign mag_b   = sign_b ? (32'd0 - bus.src_b) : bus.src_b;
  assign sum33   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign upper33 = acc_q[63:31];
  assign prod_neg = 64'd0 - acc_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    div0_d   = div0_q;
    orig_a_d = orig_a_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = (state_q == StFinish);

    case (state_q)
      StRun: begin
        if (is_div_q) begin
          if (upper33 >= {1'b0, opnd_q}) begin
            acc_d = {upper33[31:0] - opnd_q, acc_q[30:0], 1'b1};
          end else begin
            acc_d = {upper33[31:0], acc_q[30:0], 1'b0};
          end
        end else begin
          acc_d = {sum33, acc_q[31:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = StFinish;
      end
      StFinish: begin
        if (!is_div_q) begin
          {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
        end else if (div0_q) begin
          hi_d = orig_a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = neg_hi_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
          lo_d = neg_lo_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
        end
        state_d = StIdle;
      end
      default: ;
    endcase

    // A start in FINISH is taken back-to-back; HI/LO above still commit for the prior op.
    if (accept) begin
      state_d  = StRun;
      cnt_d    = 6'd0;
      is_div_d = bus.op[1];
      neg_lo_d = sign_a ^ sign_b;
      neg_hi_d = sign_a;
      div0_d   = bus.op[1] && (bus.src_b == 32'd0);
      orig_a_d = bus.src_a;
      opnd_d   = bus.op[1] ? mag_b : mag_a;
      acc_d    = bus.op[1] ? {32'd0, mag_a} : {32'd0, mag_b};
    end

    wb_rw_d   = mf_accept && (bus.mf_dst != 5'd0);
    wb_idx_d  = mf_accept ? bus.mf_dst : 5'd0;
    wb_data_d = mf_accept ? (bus.mf_sel ? hi_q : lo_q) : 32'd0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 6'd0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
      orig_a_q  <= 32'd0;
      opnd_q    <= 32'd0;
      acc_q     <= 64'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
      wb_rw_q   <= 1'b0;
      wb_idx_q  <= 5'd0;
      wb_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
      orig_a_q  <= orig_a_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      wb_rw_q   <= wb_rw_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done_q;
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.mf_stall = bus.mf_req & busy;
  assign bus.wb_rw    = wb_rw_q;
  assign bus.wb_idx   = wb_idx_q;
  assign bus.wb_data  = wb_data_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench: expected HI/LO and write-backs are queued at issue time and
// checked by a monitor whenever done or wb_rw is seen.
module tb_mul_div_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  mul_div_unit_if bus ();

  mul_div_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];   // {hi, lo}
  logic [36:0] wb_q[$];    // {idx, data}
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Monitor: any done or write-back must match the oldest queued expectation.
  always @(negedge clock) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_done", 64'd1, 64'd0);
      else chk("hi_lo", {bus.hi, bus.lo}, exp_q.pop_front());
    end
    if (bus.wb_rw === 1'b1) begin
      if (wb_q.size() == 0) chk("unexpected_wb", {27'd0, bus.wb_idx, bus.wb_data}, 64'd0);
      else chk("wb_idx_data", {27'd0, bus.wb_idx, bus.wb_data}, {27'd0, wb_q.pop_front()});
    end
  end

  // poke > 0: stray start at that busy cycle. mf_cyc 0: move-from with start;
  // mf_cyc > 0: move-from raised at that busy cycle and held until accepted.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int poke,
                        input int mf_cyc, input logic mf_s, input logic [4:0] mf_d);
    int n;
    bit stall_ok;
    @(negedge clock);
    bus.op = o; bus.src_a = a; bus.src_b = b; bus.start = 1'b1;
    exp_q.push_back({eh, el});
    if (mf_cyc == 0) begin
      bus.mf_req = 1'b1; bus.mf_sel = mf_s; bus.mf_dst = mf_d;
      if (mf_d != 5'd0) wb_q.push_back({mf_d, mf_s ? model_hi : model_lo});
    end
    @(negedge clock);
    bus.start = 1'b0; bus.src_a = ~a; bus.src_b = ~b;
    if (mf_cyc == 0) bus.mf_req = 1'b0;
    n = 0;
    stall_ok = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      if (mf_cyc > 0 && n > mf_cyc && bus.mf_stall !== 1'b1) stall_ok = 1'b0;
      bus.start = (n == poke);
      if (n == poke) bus.op = OpMultu;
      if (n == mf_cyc) begin
        bus.mf_req = 1'b1; bus.mf_sel = mf_s; bus.mf_dst = mf_d;
      end
      @(negedge clock);
    end
    bus.start = 1'b0;
    chk("busy_cycles", 64'(n), 64'd33);
    chk("done_pulse", {63'd0, bus.done}, 64'd1);
    if (mf_cyc > 0) begin
      chk("mf_stall_held", {63'd0, stall_ok}, 64'd1);
      wb_q.push_back({mf_d, mf_s ? eh : el});
      @(negedge clock);
      bus.mf_req = 1'b0;
    end
    model_hi = eh;
    model_lo = el;
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.src_a = 32'd0; bus.src_b = 32'd0;
    bus.mf_req = 1'b0; bus.mf_sel = 1'b0; bus.mf_dst = 5'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("rst_done", {63'd0, bus.done}, 64'd0);
    chk("rst_hi_lo", {bus.hi, bus.lo}, 64'd0);
    chk("rst_wb", {26'd0, bus.wb_rw, bus.wb_idx, bus.wb_data}, 64'd0);
    chk("rst_mf_stall", {63'd0, bus.mf_stall}, 64'd0);

    run_op(OpMult,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, -1, 0, 0);
    run_op(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, -1, 0, 0);
    run_op(OpMult,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 0, -1, 0, 0);
    run_op(OpDiv,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, -1, 0, 0);
    run_op(OpDiv,   32'd7,        32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 0, -1, 0, 0);
    // Move-from together with start returns the old LO (0xFFFF_FFFD).
    run_op(OpDivu,  32'd100,      32'd7,        32'd2,        32'd14, 0, 0, 1'b0, 5'd9);
    run_op(OpDiv,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,       32'h8000_0000, 0, -1, 0, 0);
    run_op(OpDivu,  32'h1234,     32'd0,        32'h1234,     32'hFFFF_FFFF, 5, -1, 0, 0);
    run_op(OpMultu, 32'hFFFF_FFFF, 32'd3,        32'd2,        32'hFFFF_FFFD, 0, 3, 1'b1, 5'd5);

    // Idle MFLO to r0 must not write; MFLO to r7 must.
    @(negedge clock);
    bus.mf_req = 1'b1; bus.mf_sel = 1'b0; bus.mf_dst = 5'd0;
    @(negedge clock);
    bus.mf_req = 1'b0;
    chk("mf_r0_no_write", {63'd0, bus.wb_rw}, 64'd0);
    bus.mf_req = 1'b1; bus.mf_sel = 1'b0; bus.mf_dst = 5'd7;
    wb_q.push_back({5'd7, model_lo});
    @(negedge clock);
    bus.mf_req = 1'b0;
    @(negedge clock);
    chk("wb_one_cycle", {63'd0, bus.wb_rw}, 64'd0);

    // Reset in the middle of a DIV aborts it without a done pulse.
    bus.op = OpDiv; bus.src_a = 32'd100; bus.src_b = 32'd7; bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", {63'd0, bus.busy}, 64'd0);
    chk("abort_hi_lo", {bus.hi, bus.lo}, 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    repeat (40) @(negedge clock);
    run_op(OpMultu, 32'd3, 32'd4, 32'd0, 32'd12, 0, -1, 0, 0);

    repeat (3) @(negedge clock);
    chk("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("wb_queue_drained", 64'(wb_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
